display_scan_mux: RTL



---
 rtl/display_scan_mux.sv | 111 +++++++++++
 1 files changed

// File: rtl/display_scan_mux.sv
// Purpose : time-multiplexes four latched BCD digits (MM:SS) onto a 4-digit 7-seg display, with pair blink.
// Latency : anode/display_state/frame_start are registered; they change on the same edge as the slot.
// Backpr. : none; free-running scan, inputs are sampled once per frame (slot 3 -> slot 0).
//
// Ports   : clk, rst_n (async active-low)
//           min_tens/min_ones/sec_tens/sec_ones - live BCD digits, captured at each frame start
//           adj, sel       - adjust mode and selected pair (0 = minutes, 1 = seconds)
//           anode          - active-low one-hot digit enable, bit 3 = leftmost (min_tens)
//           display_state  - BCD code for the enabled digit (out-of-range digits shown as 0)
//           frame_start    - one-cycle pulse in the first cycle of each newly latched frame
// Option  : define LEADING_ZERO_BLANK_EN to darken slot 0 when the latched min_tens is 0.
module display_scan_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] anode,
    output logic [3:0] display_state,
    output logic       frame_start
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // first_q marks the first edge after reset: it loads the frame and starts
    // slot 0 without advancing either counter, so slot 0 gets a full period.
    logic                first_q;
    logic [RW-1:0]       ref_cnt;
    logic [1:0]          slot;
    logic [BW-1:0]       blink_cnt;
    logic                blink_phase;
    // Element 3 = min_tens ... element 0 = sec_ones, so slot s reads element ~s.
    logic [3:0][3:0]     digits_q;

    logic                ref_tick;
    logic                blink_wrap;
    logic                slot_upd;
    logic                frame_load;
    logic [RW-1:0]       ref_cnt_nxt;
    logic [BW-1:0]       blink_cnt_nxt;
    logic                blink_phase_nxt;
    logic [1:0]          slot_nxt;
    logic [3:0][3:0]     digits_nxt;
    logic [3:0]          digit_sel;
    logic [3:0]          ds_nxt;
    logic                blank;
    logic [3:0]          anode_nxt;

    always_comb begin
        ref_tick        = !first_q && (ref_cnt == REF_LAST);
        blink_wrap      = !first_q && (blink_cnt == BLINK_LAST);
        slot_upd        = first_q || ref_tick;
        frame_load      = first_q || (ref_tick && (slot == 2'd3));

        ref_cnt_nxt     = slot_upd ? '0 : ref_cnt + RW'(1);
        blink_cnt_nxt   = first_q ? blink_cnt : (blink_wrap ? '0 : blink_cnt + BW'(1));
        blink_phase_nxt = blink_wrap ? ~blink_phase : blink_phase;
        slot_nxt        = first_q ? 2'd0 : (ref_tick ? slot + 2'd1 : slot);

        digits_nxt      = frame_load ? {min_tens, min_ones, sec_tens, sec_ones} : digits_q;
        digit_sel       = digits_nxt[~slot_nxt];
        ds_nxt          = (digit_sel > 4'd9) ? 4'd0 : digit_sel;

        // Slots 2/3 are the seconds pair; blank the selected pair in the dark phase.
        blank           = adj && !blink_phase_nxt && (slot_nxt[1] == sel);
`ifdef LEADING_ZERO_BLANK_EN
        if ((slot_nxt == 2'd0) && (digits_nxt[3] == 4'd0)) begin
            blank = 1'b1;
        end
`else
`endif
        anode_nxt       = blank ? 4'b1111 : ~(4'b1000 >> slot_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q       <= 1'b1;
            ref_cnt       <= '0;
            slot          <= 2'd0;
            blink_cnt     <= '0;
            blink_phase   <= 1'b1;
            digits_q      <= '0;
            anode         <= 4'b1111;
            display_state <= 4'd0;
            frame_start   <= 1'b0;
        end else begin
            first_q     <= 1'b0;
            ref_cnt     <= ref_cnt_nxt;
            slot        <= slot_nxt;
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            digits_q    <= digits_nxt;
            frame_start <= frame_load;
            // adj/sel/blink are only sampled at slot updates: no mid-slot flicker.
            if (slot_upd) begin
                anode         <= anode_nxt;
                display_state <= ds_nxt;
            end
        end
    end

endmodule
